// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//   Decode stage for the 8-bit byte-serial CPU. It consumes one instruction
//   byte per "fresh" fetch cycle, assembles one- and two-byte instructions,
//   emits a one-cycle dec_valid pulse with the decoded fields, and raises a
//   one-cycle branch request for JMP and taken BZ. After a branch the two
//   sequential bytes still in flight are flushed. HALT (0xF) is absorbing
//   until reset.
//
// Ports
//   clk              in   clock, rising edge
//   rstn             in   asynchronous active-low reset
//   suspend_cpu      in   phase stall, shared with the fetch stage
//   instr_rdata[7:0] in   memory data for the address presented last cycle
//   zero_flag        in   execute-stage zero flag, sampled for BZ
//   pc_take_branch   out  registered one-cycle branch request
//   pc_branch_target out  registered branch target (immediate, unchanged)
//   dec_valid        out  one-cycle pulse, decoded fields valid
//   dec_opcode[3:0]  out  instr[7:4]
//   dec_rd[1:0]      out  instr[3:2]
//   dec_rs[1:0]      out  instr[1:0]
//   dec_imm[7:0]     out  second byte of a two-byte instruction, else 0
//   dec_illegal      out  opcode 0xD or 0xE, qualifies dec_valid
//   halted           out  high while in HALT
// ---------------------------------------------------------------------------
module instruction_decode (
    input  logic       clk,
    input  logic       rstn,
    input  logic       suspend_cpu,
    input  logic [7:0] instr_rdata,
    input  logic       zero_flag,
    output logic       pc_take_branch,
    output logic [7:0] pc_branch_target,
    output logic       dec_valid,
    output logic [3:0] dec_opcode,
    output logic [1:0] dec_rd,
    output logic [1:0] dec_rs,
    output logic [7:0] dec_imm,
    output logic       dec_illegal,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_OP     = 3'd0,
        ST_IMM    = 3'd1,
        ST_FLUSH1 = 3'd2,
        ST_FLUSH2 = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // LDI, JMP and BZ carry an immediate byte
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == 4'h8) || (op == 4'hB) || (op == 4'hC);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'hD) || (op == 4'hE);
    endfunction

    function automatic logic is_taken(input logic [3:0] op, input logic zf);
        return (op == 4'hB) || ((op == 4'hC) && zf);
    endfunction

    state_t     state_q, state_d;
    logic       addr_new_q, byte_fresh_q;
    logic [7:0] op_lat_q, op_lat_d;
    logic       take_q, take_d;
    logic [7:0] target_q, target_d;
    logic       valid_q, valid_d;
    logic [3:0] opcode_q, opcode_d;
    logic [1:0] rd_q, rd_d;
    logic [1:0] rs_q, rs_d;
    logic [7:0] imm_q, imm_d;
    logic       illegal_q, illegal_d;
    logic       halted_q, halted_d;
    logic [3:0] op_in_s;

    assign op_in_s = instr_rdata[7:4];

    // State register and byte-freshness tracking.
    // A byte is fresh when the address it was read from was newly presented,
    // i.e. the PC moved (branch or un-stalled increment) on the edge before.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_OP;
            addr_new_q   <= 1'b1;
            byte_fresh_q <= 1'b0;
            op_lat_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            addr_new_q   <= take_q | ~suspend_cpu;
            byte_fresh_q <= addr_new_q;
            op_lat_q     <= op_lat_d;
        end
    end

    // Next-state logic; stale (non-fresh) cycles hold the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OP: begin
                if (byte_fresh_q) begin
                    if (op_in_s == 4'hF) begin
                        state_d = ST_HALT;
                    end else if (is_two_byte(op_in_s)) begin
                        state_d = ST_IMM;
                    end else begin
                        state_d = ST_OP;
                    end
                end else begin
                    state_d = ST_OP;
                end
            end
            ST_IMM: begin
                if (byte_fresh_q) begin
                    if (is_taken(op_lat_q[7:4], zero_flag)) begin
                        state_d = ST_FLUSH1;
                    end else begin
                        state_d = ST_OP;
                    end
                end else begin
                    state_d = ST_IMM;
                end
            end
            // two bytes from the old sequential stream are still in flight
            ST_FLUSH1: state_d = ST_FLUSH2;
            ST_FLUSH2: state_d = ST_OP;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_OP;
        endcase
    end

    // Output next-values; pulses default low, fields hold their last value.
    always_comb begin
        valid_d   = 1'b0;
        take_d    = 1'b0;
        target_d  = target_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        op_lat_d  = op_lat_q;
        case (state_q)
            ST_OP: begin
                if (byte_fresh_q) begin
                    if (is_two_byte(op_in_s)) begin
                        op_lat_d = instr_rdata;
                    end else begin
                        valid_d   = 1'b1;
                        opcode_d  = op_in_s;
                        rd_d      = instr_rdata[3:2];
                        rs_d      = instr_rdata[1:0];
                        imm_d     = 8'h00;
                        illegal_d = is_illegal(op_in_s);
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_IMM: begin
                if (byte_fresh_q) begin
                    valid_d   = 1'b1;
                    opcode_d  = op_lat_q[7:4];
                    rd_d      = op_lat_q[3:2];
                    rs_d      = op_lat_q[1:0];
                    imm_d     = instr_rdata;
                    illegal_d = 1'b0;
                    if (is_taken(op_lat_q[7:4], zero_flag)) begin
                        take_d   = 1'b1;
                        target_d = instr_rdata;
                    end else begin
                        take_d = 1'b0;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            take_q    <= 1'b0;
            target_q  <= 8'h00;
            valid_q   <= 1'b0;
            opcode_q  <= 4'h0;
            rd_q      <= 2'd0;
            rs_q      <= 2'd0;
            imm_q     <= 8'h00;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            take_q    <= take_d;
            target_q  <= target_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    assign pc_take_branch   = take_q;
    assign pc_branch_target = target_q;
    assign dec_valid        = valid_q;
    assign dec_opcode       = opcode_q;
    assign dec_rd           = rd_q;
    assign dec_rs           = rs_q;
    assign dec_imm          = imm_q;
    assign dec_illegal      = illegal_q;
    assign halted           = halted_q;

endmodule
